// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART-to-ALU packet framing stage.
package uart_alu_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;
  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_BAD_LEN = 2'd1, ERR_TIMEOUT = 2'd2, ERR_BAD_OPCODE = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_DRAIN
  } state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return b inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
  endfunction
endpackage

// File: rtl/uart_alu_pkt_parser_if.sv
// Byte stream in from the UART receiver, packed word stream out to the ALU.
interface uart_alu_pkt_parser_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 4
);
  logic [DATA_WIDTH-1:0]            s_axis_tdata;
  logic                             s_axis_tvalid;
  logic                             s_axis_tready;
  logic [DATA_WIDTH*WORD_BYTES-1:0] m_word_o;
  logic [DATA_WIDTH-1:0]            m_opcode_o;
  logic [2:0]                       m_nbytes_o;
  logic                             m_first_o;
  logic                             m_last_o;
  logic                             m_valid_o;
  logic                             m_ready_i;

  // slave: the parser's view; master: the surrounding environment
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_ready_i,
    output s_axis_tready, m_word_o, m_opcode_o, m_nbytes_o, m_first_o, m_last_o, m_valid_o
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_ready_i,
    input  s_axis_tready, m_word_o, m_opcode_o, m_nbytes_o, m_first_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/uart_rx_timeout.sv
// Idle-gap watchdog: clears on demand, counts enabled cycles, flags the terminal count.
module uart_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 65625
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + CW'(1);
  end

  // fires on the cycle whose increment reaches the limit, so abort lands on that edge
  assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/uart_alu_pkt_parser.sv
// Parses opcode/reserved/length header, validates length, packs payload LE into words.
module uart_alu_pkt_parser
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 65625
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_alu_pkt_parser_if.slave bus,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic                 busy_o
);
  localparam int IDX_W = $clog2(WORD_BYTES);

  state_e    state_q, state_d;
  err_code_e err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0]                  opcode_q;
  logic [7:0]                             len_lo_q;
  logic [15:0]                            rem_q, len, payload;
  logic [IDX_W-1:0]                       byte_idx_q;
  logic [WORD_BYTES-1:0][DATA_WIDTH-1:0]  wbuf_q, word_d;
  logic first_q, accept, tmo_expired;
  logic err_set, op_ld, lo_ld, rem_ld, wr_byte, word_ld, last_byte, abort;

  assign bus.s_axis_tready = !(state_q == ST_PAYLOAD && bus.m_valid_o && !bus.m_ready_i);
  assign accept  = bus.s_axis_tvalid && bus.s_axis_tready;
  assign busy_o  = (state_q != ST_IDLE);
  assign len     = {bus.s_axis_tdata[7:0], len_lo_q};
  assign payload = len - 16'(HDR_BYTES);
  assign err_code_o = err_code_q;

  uart_rx_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (accept || state_q == ST_IDLE),
    .inc_i     (busy_o && bus.s_axis_tready && !bus.s_axis_tvalid),
    .expired_o (tmo_expired)
  );

  // outgoing word = buffer with the byte arriving this cycle merged into its lane
  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
    assign word_d[g] = (byte_idx_q == IDX_W'(g)) ? bus.s_axis_tdata : wbuf_q[g];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q; err_set = 1'b0; err_code_d = ERR_NONE;
    op_ld = 1'b0; lo_ld = 1'b0; rem_ld = 1'b0; wr_byte = 1'b0;
    word_ld = 1'b0; last_byte = 1'b0; abort = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        if (is_opcode(bus.s_axis_tdata)) begin op_ld = 1'b1; state_d = ST_RSVD; end
        else begin err_set = 1'b1; err_code_d = ERR_BAD_OPCODE; end
      end
      ST_RSVD:   if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: if (accept) begin lo_ld = 1'b1; state_d = ST_LEN_HI; end
      ST_LEN_HI: if (accept) begin
        if (len < 16'(HDR_BYTES)) begin
          err_set = 1'b1; err_code_d = ERR_BAD_LEN; state_d = ST_IDLE;
        end else if (opcode_q == OP_ECHO) begin
          rem_ld  = (payload != 16'd0);
          state_d = rem_ld ? ST_PAYLOAD : ST_IDLE;
        end else if (payload[1:0] != 2'd0 || payload < 16'd8) begin
          // malformed arithmetic operands are swallowed so framing stays aligned
          err_set = 1'b1; err_code_d = ERR_BAD_LEN; rem_ld = 1'b1;
          state_d = (payload == 16'd0) ? ST_IDLE : ST_DRAIN;
        end else begin
          rem_ld = 1'b1; state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (accept) begin
        wr_byte   = 1'b1;
        last_byte = (rem_q == 16'd1);
        word_ld   = last_byte || (byte_idx_q == IDX_W'(WORD_BYTES - 1));
        if (last_byte) state_d = ST_IDLE;
      end
      ST_DRAIN: if (accept && rem_q == 16'd1) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (tmo_expired) begin
      state_d = ST_IDLE; err_set = 1'b1; err_code_d = ERR_TIMEOUT; abort = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode_q <= '0; len_lo_q <= '0; rem_q <= '0; byte_idx_q <= '0; wbuf_q <= '0;
      first_q <= 1'b0; err_o <= 1'b0; err_code_q <= ERR_NONE;
      bus.m_valid_o <= 1'b0; bus.m_word_o <= '0; bus.m_opcode_o <= '0;
      bus.m_nbytes_o <= '0; bus.m_first_o <= 1'b0; bus.m_last_o <= 1'b0;
    end else begin
      if (op_ld) opcode_q <= bus.s_axis_tdata;
      if (lo_ld) len_lo_q <= bus.s_axis_tdata[7:0];
      if (rem_ld) rem_q <= payload;
      else if (accept && (state_q == ST_PAYLOAD || state_q == ST_DRAIN)) rem_q <= rem_q - 16'd1;
      if (rem_ld || abort || word_ld) begin
        byte_idx_q <= '0; wbuf_q <= '0;
      end else if (wr_byte) begin
        byte_idx_q <= byte_idx_q + IDX_W'(1);
        wbuf_q[byte_idx_q] <= bus.s_axis_tdata;
      end
      if (rem_ld)       first_q <= 1'b1;
      else if (word_ld) first_q <= 1'b0;
      if (word_ld) begin
        bus.m_valid_o  <= 1'b1;
        bus.m_word_o   <= word_d;
        bus.m_opcode_o <= opcode_q;
        bus.m_nbytes_o <= 3'(byte_idx_q) + 3'd1;
        bus.m_first_o  <= first_q;
        bus.m_last_o   <= last_byte;
      end else if (bus.m_valid_o && bus.m_ready_i) begin
        bus.m_valid_o <= 1'b0;
      end
      err_o <= err_set;
      if (err_set) err_code_q <= err_code_d;
    end
  end
endmodule
